// File: rtl/inst_fetch_bridge_pkg.sv
// Shared types and constants for the instruction fetch bridge.
// The tag is the word address of a fetch; the low two address bits never reach the bus.
package inst_fetch_bridge_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TAG_W  = ADDR_W - 2;

  localparam logic [DATA_W-1:0] NOP_INST_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FB_IDLE = 1'b0,
    FB_REQ  = 1'b1
  } fb_state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:2];
  endfunction

  // Width of a counter that must be able to reach the timeout value itself.
  function automatic int cnt_width(input int timeout);
    if (timeout < 1) begin
      return 1;
    end
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/inst_fetch_bridge.sv
// One-entry tagged fetch buffer between the core's instruction port and a
// wait-stated req/ack instruction bus; a held PC never re-reads the bus.
module inst_fetch_bridge
  import inst_fetch_bridge_pkg::*;
#(
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              inv_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              stallreq_o,
  output logic              err_o,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  input  logic              bus_ack_i,
  input  logic              bus_err_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  localparam int             CNT_W      = cnt_width(int'(TIMEOUT));
  localparam bit             TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  fb_state_t         state_reg, state_next;
  logic              buf_valid_reg, buf_valid_next;
  logic [TAG_W-1:0]  buf_tag_reg, buf_tag_next;
  logic [DATA_W-1:0] buf_data_reg, buf_data_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              bus_req_reg, bus_req_next;
  logic [ADDR_W-1:0] bus_addr_reg, bus_addr_next;
  logic              err_reg, err_next;

  logic              hit;
  logic              timeout_hit;
  logic              addr_lsb_unused;

  assign addr_lsb_unused = ^cpu_addr_i[1:0];
  assign timeout_hit     = TIMEOUT_EN && (cnt_reg == CNT_LAST);

  // Hit/stall path: only an idle bridge may serve from the buffer.
  always_comb begin
    hit        = cpu_ce_i && buf_valid_reg && (buf_tag_reg == addr_tag(cpu_addr_i))
                 && (state_reg == FB_IDLE);
    cpu_data_o = hit ? buf_data_reg : '0;
    stallreq_o = rst && cpu_ce_i && !hit;
  end

  always_comb begin
    state_next     = state_reg;
    buf_valid_next = buf_valid_reg;
    buf_tag_next   = buf_tag_reg;
    buf_data_next  = buf_data_reg;
    cnt_next       = cnt_reg;
    bus_req_next   = bus_req_reg;
    bus_addr_next  = bus_addr_reg;
    err_next       = 1'b0;

    case (state_reg)
      FB_IDLE: begin
        if (cpu_ce_i && !hit) begin
          state_next    = FB_REQ;
          bus_req_next  = 1'b1;
          bus_addr_next = {addr_tag(cpu_addr_i), 2'b00};
          cnt_next      = '0;
        end
      end
      FB_REQ: begin
        cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
        // A request always completes under the tag it was issued with,
        // even if the core has since moved on; IDLE then re-evaluates.
        if (bus_ack_i || timeout_hit) begin
          state_next     = FB_IDLE;
          bus_req_next   = 1'b0;
          buf_valid_next = 1'b1;
          buf_tag_next   = addr_tag(bus_addr_reg);
          buf_data_next  = (bus_ack_i && !bus_err_i) ? bus_rdata_i : NOP_INST;
          err_next       = !bus_ack_i || bus_err_i;
        end
      end
      default: begin
        state_next   = FB_IDLE;
        bus_req_next = 1'b0;
      end
    endcase

    // Invalidate beats a same-cycle fill so the word is fetched again.
    if (inv_i) begin
      buf_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= FB_IDLE;
      buf_valid_reg <= 1'b0;
      buf_tag_reg   <= '0;
      buf_data_reg  <= '0;
      cnt_reg       <= '0;
      bus_req_reg   <= 1'b0;
      bus_addr_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      buf_valid_reg <= buf_valid_next;
      buf_tag_reg   <= buf_tag_next;
      buf_data_reg  <= buf_data_next;
      cnt_reg       <= cnt_next;
      bus_req_reg   <= bus_req_next;
      bus_addr_reg  <= bus_addr_next;
      err_reg       <= err_next;
    end
  end

  assign bus_req_o  = bus_req_reg;
  assign bus_addr_o = bus_addr_reg;
  assign err_o      = err_reg;

endmodule
